// File: rtl/cpu_seq.sv
// cpu_seq: multi-cycle instruction sequencer for the l2 core.
// Gates PC/GPR/RAM commits to one pulse per instruction; traps on memory timeout.
module cpu_seq #(
  parameter int INST_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int TIMEOUT    = 256,
  parameter int SKIP_LS    = 1
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_sys_halt,
  output logic                  o_sys_busy,
  output logic                  o_ifu_req_valid,
  input  logic                  i_ifu_req_ready,
  input  logic                  i_ram_inst_valid,
  input  logic [INST_WIDTH-1:0] i_ram_inst,
  output logic [INST_WIDTH-1:0] o_idu_inst,
  output logic                  o_idu_inst_valid,
  input  logic                  i_idu_ctr_ram_rd_en,
  input  logic                  i_idu_ctr_ram_wr_en,
  input  logic                  i_idu_ctr_reg_wr_en,
  output logic                  o_lsu_req_valid,
  input  logic                  i_lsu_req_ready,
  input  logic                  i_lsu_resp_valid,
  output logic                  o_lsu_ram_wr_en,
  output logic                  o_wbu_gpr_wr_en,
  output logic                  o_ifu_pc_upd_en,
  output logic [3:0]            o_seq_state,
  output logic [CNT_WIDTH-1:0]  o_retire_cnt,
  output logic                  o_err
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_IF   = 4'd1,
    S_IFW  = 4'd2,
    S_ID   = 4'd3,
    S_EX   = 4'd4,
    S_LS   = 4'd5,
    S_LSW  = 4'd6,
    S_WB   = 4'd7,
    S_ERR  = 4'd8
  } state_e;

  state_e                state_q, state_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  rw_q, rw_d;
  logic [CNT_WIDTH-1:0]  ret_q, ret_d;
  logic                  mem_op;
  logic                  wait_exp;

  assign mem_op   = rd_q | wr_q;
  assign wait_exp = (wait_q == WAIT_LAST);

  always_comb begin
    state_d         = state_q;
    wait_d          = wait_q;
    inst_d          = inst_q;
    rd_d            = rd_q;
    wr_d            = wr_q;
    rw_d            = rw_q;
    ret_d           = ret_q;
    o_ifu_req_valid = 1'b0;
    o_lsu_req_valid = 1'b0;
    o_lsu_ram_wr_en = 1'b0;
    o_wbu_gpr_wr_en = 1'b0;
    o_ifu_pc_upd_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!i_sys_halt) state_d = S_IF;
      end
      S_IF: begin
        o_ifu_req_valid = 1'b1;
        if (i_ifu_req_ready) begin
          if (i_ram_inst_valid) begin
            inst_d  = i_ram_inst;
            state_d = S_ID;
          end else begin
            state_d = S_IFW;
          end
        end else if (wait_exp) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_IFW: begin
        if (i_ram_inst_valid) begin
          inst_d  = i_ram_inst;
          state_d = S_ID;
        end else if (wait_exp) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_ID: begin
        rd_d = i_idu_ctr_ram_rd_en;
        wr_d = i_idu_ctr_ram_wr_en;
        rw_d = i_idu_ctr_reg_wr_en;
        if (i_idu_ctr_ram_rd_en && i_idu_ctr_ram_wr_en)
          state_d = S_ERR;
        else
          state_d = S_EX;
      end
      S_EX: begin
        if (mem_op || (SKIP_LS == 0))
          state_d = S_LS;
        else
          state_d = S_WB;
      end
      S_LS: begin
        if (!mem_op) begin
          state_d = S_WB;
        end else begin
          o_lsu_req_valid = 1'b1;
          if (i_lsu_req_ready) begin
            if (wr_q) begin
              o_lsu_ram_wr_en = 1'b1;
              state_d         = S_WB;
            end else if (i_lsu_resp_valid) begin
              state_d = S_WB;
            end else begin
              state_d = S_LSW;
            end
          end else if (wait_exp) begin
            state_d = S_ERR;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end
      end
      S_LSW: begin
        if (i_lsu_resp_valid)
          state_d = S_WB;
        else if (wait_exp)
          state_d = S_ERR;
        else
          wait_d = wait_q + WW'(1);
      end
      S_WB: begin
        o_ifu_pc_upd_en = 1'b1;
        o_wbu_gpr_wr_en = rw_q;
        ret_d           = ret_q + CNT_WIDTH'(1);
        state_d         = i_sys_halt ? S_IDLE : S_IF;
      end
      default: state_d = S_ERR;
    endcase
    // every wait window starts from zero on state entry
    if (state_d != state_q) wait_d = '0;
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      inst_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rw_q    <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      inst_q  <= inst_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rw_q    <= rw_d;
      ret_q   <= ret_d;
    end
  end

  assign o_seq_state      = state_q;
  assign o_sys_busy       = (state_q != S_IDLE) && (state_q != S_ERR);
  assign o_idu_inst       = inst_q;
  assign o_idu_inst_valid = (state_q == S_ID) || (state_q == S_EX) ||
                            (state_q == S_LS) || (state_q == S_LSW) ||
                            (state_q == S_WB);
  assign o_retire_cnt     = ret_q;
  assign o_err            = (state_q == S_ERR);

endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: transaction-level expected traces for two cpu_seq configs,
// replayed cycle by cycle and compared on the falling edge.
module tb_cpu_seq;

  localparam int TO0 = 4;
  localparam int CW0 = 4;
  localparam int TO1 = 8;
  localparam int CW1 = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_rst[2];
  logic        s_halt[2];
  logic        s_ifr[2];
  logic        s_iv[2];
  logic [31:0] s_inst[2];
  logic        s_rd[2];
  logic        s_wr[2];
  logic        s_rw[2];
  logic        s_lr[2];
  logic        s_rv[2];

  logic        o_busy[2];
  logic        o_ifv[2];
  logic [31:0] o_inst[2];
  logic        o_ivld[2];
  logic        o_lsv[2];
  logic        o_swr[2];
  logic        o_gwr[2];
  logic        o_pcu[2];
  logic [3:0]  o_st[2];
  logic        o_err[2];
  logic [3:0]  ret0;
  logic [31:0] ret1;

  cpu_seq #(
    .INST_WIDTH(32), .CNT_WIDTH(CW0), .TIMEOUT(TO0), .SKIP_LS(1)
  ) u0 (
    .i_sys_clk(clk), .i_sys_rst(s_rst[0]), .i_sys_halt(s_halt[0]),
    .o_sys_busy(o_busy[0]), .o_ifu_req_valid(o_ifv[0]),
    .i_ifu_req_ready(s_ifr[0]), .i_ram_inst_valid(s_iv[0]),
    .i_ram_inst(s_inst[0]), .o_idu_inst(o_inst[0]),
    .o_idu_inst_valid(o_ivld[0]), .i_idu_ctr_ram_rd_en(s_rd[0]),
    .i_idu_ctr_ram_wr_en(s_wr[0]), .i_idu_ctr_reg_wr_en(s_rw[0]),
    .o_lsu_req_valid(o_lsv[0]), .i_lsu_req_ready(s_lr[0]),
    .i_lsu_resp_valid(s_rv[0]), .o_lsu_ram_wr_en(o_swr[0]),
    .o_wbu_gpr_wr_en(o_gwr[0]), .o_ifu_pc_upd_en(o_pcu[0]),
    .o_seq_state(o_st[0]), .o_retire_cnt(ret0), .o_err(o_err[0])
  );

  cpu_seq #(
    .INST_WIDTH(32), .CNT_WIDTH(CW1), .TIMEOUT(TO1), .SKIP_LS(0)
  ) u1 (
    .i_sys_clk(clk), .i_sys_rst(s_rst[1]), .i_sys_halt(s_halt[1]),
    .o_sys_busy(o_busy[1]), .o_ifu_req_valid(o_ifv[1]),
    .i_ifu_req_ready(s_ifr[1]), .i_ram_inst_valid(s_iv[1]),
    .i_ram_inst(s_inst[1]), .o_idu_inst(o_inst[1]),
    .o_idu_inst_valid(o_ivld[1]), .i_idu_ctr_ram_rd_en(s_rd[1]),
    .i_idu_ctr_ram_wr_en(s_wr[1]), .i_idu_ctr_reg_wr_en(s_rw[1]),
    .o_lsu_req_valid(o_lsv[1]), .i_lsu_req_ready(s_lr[1]),
    .i_lsu_resp_valid(s_rv[1]), .o_lsu_ram_wr_en(o_swr[1]),
    .o_wbu_gpr_wr_en(o_gwr[1]), .o_ifu_pc_upd_en(o_pcu[1]),
    .o_seq_state(o_st[1]), .o_retire_cnt(ret1), .o_err(o_err[1])
  );

  typedef struct {
    bit          rst, halt, ifr, iv, rd, wr, rw, lr, rv;
    logic [31:0] inst;
  } in_t;

  typedef struct {
    in_t         i;
    int          st;
    bit          lsv, swr, gwr, pcu;
    logic [31:0] inst;
    logic [31:0] ret;
  } cyc_t;

  cyc_t        q[$];
  cyc_t        cur;
  int          cur_k;
  bit          chk_en;
  int          n_chk;
  int          n_err;
  int          cyc;
  logic [31:0] m_inst;
  logic [31:0] m_ret;
  bit          m_err;

  function automatic int to_of(int k);
    return (k == 0) ? TO0 : TO1;
  endfunction

  function automatic bit skip_of(int k);
    return k == 0;
  endfunction

  function automatic logic [31:0] mask_of(int k);
    return (k == 0) ? 32'h0000_000F : 32'hFFFF_FFFF;
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic bit pct(int p);
    return $urandom_range(0, 99) < p;
  endfunction

  function automatic in_t noise();
    in_t i;
    i.rst  = 1'b0;
    i.halt = rb();
    i.ifr  = rb();
    i.iv   = rb();
    i.rd   = rb();
    i.wr   = rb();
    i.rw   = rb();
    i.lr   = rb();
    i.rv   = rb();
    i.inst = $urandom;
    return i;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic push(in_t i, int st, bit lsv, bit swr, bit gwr, bit pcu);
    cyc_t c;
    c.i    = i;
    c.st   = st;
    c.lsv  = lsv;
    c.swr  = swr;
    c.gwr  = gwr;
    c.pcu  = pcu;
    c.inst = m_inst;
    c.ret  = m_ret;
    q.push_back(c);
  endtask

  task automatic go_err();
    repeat (3) push(noise(), 8, 0, 0, 0, 0);
    m_err = 1'b1;
  endtask

  // reset cycles, then one idle cycle that releases into fetch
  task automatic do_reset(int n);
    in_t i;
    m_inst = '0;
    m_ret  = '0;
    m_err  = 1'b0;
    repeat (n) begin
      i     = noise();
      i.rst = 1'b1;
      push(i, 0, 0, 0, 0, 0);
    end
    i      = noise();
    i.halt = 1'b0;
    push(i, 0, 0, 0, 0, 0);
  endtask

  // One instruction starting in fetch. Delays count wait cycles before the
  // awaited event; a wait window of TIMEOUT cycles with no event traps.
  task automatic instr(int k, int fd, int vd, logic [31:0] w,
                       bit f_rd, bit f_wr, bit f_rw, int ld, int rdly,
                       bit halt, int idle_n);
    int  to;
    bit  mem;
    in_t i;
    to  = to_of(k);
    mem = f_rd | f_wr;
    for (int c = 0; c < fd && c < to; c++) begin
      i     = noise();
      i.ifr = 1'b0;
      push(i, 1, 0, 0, 0, 0);
    end
    if (fd >= to) begin
      go_err();
      return;
    end
    i     = noise();
    i.ifr = 1'b1;
    i.iv  = (vd == 0);
    if (vd == 0) i.inst = w;
    push(i, 1, 0, 0, 0, 0);
    if (vd > 0) begin
      for (int c = 1; c <= vd && c <= to; c++) begin
        i    = noise();
        i.iv = (c == vd);
        if (c == vd) i.inst = w;
        push(i, 2, 0, 0, 0, 0);
      end
      if (vd > to) begin
        go_err();
        return;
      end
    end
    m_inst = w;
    i    = noise();
    i.rd = f_rd;
    i.wr = f_wr;
    i.rw = f_rw;
    push(i, 3, 0, 0, 0, 0);
    if (f_rd && f_wr) begin
      go_err();
      return;
    end
    push(noise(), 4, 0, 0, 0, 0);
    if (mem || !skip_of(k)) begin
      if (!mem) begin
        push(noise(), 5, 0, 0, 0, 0);
      end else begin
        for (int c = 0; c < ld && c < to; c++) begin
          i    = noise();
          i.lr = 1'b0;
          push(i, 5, 1, 0, 0, 0);
        end
        if (ld >= to) begin
          go_err();
          return;
        end
        i    = noise();
        i.lr = 1'b1;
        if (f_wr) begin
          push(i, 5, 1, 1, 0, 0);
        end else begin
          i.rv = (rdly == 0);
          push(i, 5, 1, 0, 0, 0);
          for (int c = 1; c <= rdly && c <= to; c++) begin
            i    = noise();
            i.rv = (c == rdly);
            push(i, 6, 0, 0, 0, 0);
          end
          if (rdly > to) begin
            go_err();
            return;
          end
        end
      end
    end
    i      = noise();
    i.halt = halt;
    push(i, 7, 0, 0, f_rw, 1);
    m_ret = (m_ret + 32'd1) & mask_of(k);
    if (halt) begin
      repeat (idle_n) begin
        i      = noise();
        i.halt = 1'b1;
        push(i, 0, 0, 0, 0, 0);
      end
      i      = noise();
      i.halt = 1'b0;
      push(i, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic rnd_instr(int k);
    int to, fd, vd, ld, rdly, kind, s, n;
    bit f_rd, f_wr, f_rw;
    to   = to_of(k);
    fd   = pct(6) ? to + $urandom_range(0, 1) : $urandom_range(0, to - 1);
    vd   = pct(6) ? to + 1 : (pct(40) ? 0 : $urandom_range(1, to));
    ld   = pct(6) ? to + $urandom_range(0, 1) : $urandom_range(0, to - 1);
    rdly = pct(6) ? to + 1 : (pct(40) ? 0 : $urandom_range(1, to));
    kind = $urandom_range(0, 9);
    f_rd = (kind == 5) || (kind == 6);
    f_wr = (kind == 7) || (kind == 8);
    f_rw = (kind < 4) || f_rd || rb();
    if (kind == 9 && pct(40)) begin
      f_rd = 1'b1;
      f_wr = 1'b1;
    end
    s = q.size();
    instr(k, fd, vd, $urandom, f_rd, f_wr, f_rw, ld, rdly, pct(15),
          $urandom_range(0, 3));
    if (m_err) begin
      do_reset($urandom_range(1, 2));
    end else if (pct(7)) begin
      n = $urandom_range(1, q.size() - s);
      repeat (n) void'(q.pop_back());
      do_reset($urandom_range(1, 2));
    end
  endtask

  function automatic int cnt_st(int from, int st);
    int n = 0;
    for (int j = from; j < q.size(); j++) if (q[j].st == st) n++;
    return n;
  endfunction

  task automatic apply(int k, in_t i);
    s_rst[k]  = i.rst;
    s_halt[k] = i.halt;
    s_ifr[k]  = i.ifr;
    s_iv[k]   = i.iv;
    s_inst[k] = i.inst;
    s_rd[k]   = i.rd;
    s_wr[k]   = i.wr;
    s_rw[k]   = i.rw;
    s_lr[k]   = i.lr;
    s_rv[k]   = i.rv;
  endtask

  task automatic play(int k);
    for (int j = 0; j < q.size(); j++) begin
      @(posedge clk);
      #1;
      apply(k, q[j].i);
      cur    = q[j];
      cur_k  = k;
      chk_en = 1'b1;
      cyc++;
    end
    @(posedge clk);
    #1;
    chk_en   = 1'b0;
    s_rst[k] = 1'b1;
    q.delete();
  endtask

  always @(negedge clk) begin : cmp
    int          k;
    int          st;
    logic [31:0] ret;
    if (chk_en) begin
      k   = cur_k;
      st  = cur.st;
      ret = (k == 0) ? {28'd0, ret0} : ret1;
      chk("state", 32'(o_st[k]), 32'(st));
      chk("ifu_req_valid", 32'(o_ifv[k]), 32'(st == 1));
      chk("lsu_req_valid", 32'(o_lsv[k]), 32'(cur.lsv));
      chk("lsu_ram_wr_en", 32'(o_swr[k]), 32'(cur.swr));
      chk("wbu_gpr_wr_en", 32'(o_gwr[k]), 32'(cur.gwr));
      chk("ifu_pc_upd_en", 32'(o_pcu[k]), 32'(cur.pcu));
      chk("sys_busy", 32'(o_busy[k]), 32'(st != 0 && st != 8));
      chk("err", 32'(o_err[k]), 32'(st == 8));
      chk("idu_inst_valid", 32'(o_ivld[k]), 32'(st >= 3 && st <= 7));
      chk("idu_inst", o_inst[k], cur.inst);
      chk("retire_cnt", ret, cur.ret);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end

  initial begin
    int s, s2, s3, nl, nw, ng;
    n_chk  = 0;
    n_err  = 0;
    cyc    = 0;
    chk_en = 1'b0;
    m_err  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_t z;
      z     = noise();
      z.rst = 1'b1;
      apply(k, z);
    end

    // config 0: TIMEOUT=4, CNT_WIDTH=4, LS skipped for ALU ops
    do_reset(2);
    s = q.size();
    instr(0, 0, 0, 32'h0000_0013, 0, 0, 1, 0, 0, 0, 0);
    chk("pin_alu_retire", m_ret, 32'd1);
    s2 = q.size();
    instr(0, 0, 0, 32'h0020_A023, 0, 1, 0, 3, 0, 0, 0);
    chk("pin_alu_seq", 32'(q[s].st * 10000 + q[s+1].st * 1000 +
        q[s+2].st * 100 + q[s+3].st * 10 + q[s+4].st), 32'd13471);
    chk("pin_alu_wb", 32'({q[s+3].gwr, q[s+3].pcu}), 32'b11);
    nl = 0;
    nw = 0;
    ng = 0;
    for (int j = s2; j < q.size(); j++) begin
      nl += int'(q[j].lsv);
      nw += int'(q[j].swr);
      ng += int'(q[j].gwr);
    end
    chk("pin_st_req_cycles", 32'(nl), 32'd4);
    chk("pin_st_pulses", 32'(nw), 32'd1);
    chk("pin_st_gpr", 32'(ng), 32'd0);
    instr(0, 1, 2, 32'h0010_0093, 0, 0, 1, 0, 0, 1, 3);
    instr(0, 0, 0, 32'h0010_0113, 0, 0, 1, 0, 0, 0, 0);
    s3 = q.size();
    instr(0, 0, 9, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    chk("pin_ifw_timeout", 32'(cnt_st(s3, 2)), 32'd4);
    chk("pin_trap", 32'(m_err), 32'd1);
    do_reset(1);
    s3 = q.size();
    instr(0, 0, 0, 32'hDEAD_BEEF, 1, 1, 1, 0, 0, 0, 0);
    chk("pin_rdwr_trap", 32'(cnt_st(s3, 4)), 32'd0);
    do_reset(1);
    repeat (16) instr(0, 0, 0, 32'h0000_0013, 0, 0, 1, 0, 0, 0, 0);
    chk("pin_wrap", m_ret, 32'd0);
    repeat (150) rnd_instr(0);
    play(0);

    // config 1: TIMEOUT=8, CNT_WIDTH=32, every instruction visits LS
    do_reset(2);
    s = q.size();
    instr(1, 0, 0, 32'h00A1_2083, 1, 0, 1, 0, 5, 0, 0);
    chk("pin_lsw_cycles", 32'(cnt_st(s, 6)), 32'd5);
    chk("pin_load_gpr", 32'(q[q.size()-1].gwr), 32'd1);
    s = q.size();
    instr(1, 0, 0, 32'h0000_0013, 0, 0, 1, 0, 0, 0, 0);
    chk("pin_noskip_ls", 32'(cnt_st(s, 5)), 32'd1);
    instr(1, 0, 1, 32'h00A1_2083, 1, 0, 1, 2, 6, 0, 0);
    while (q[$].st != 6) void'(q.pop_back());
    void'(q.pop_back());
    do_reset(1);
    instr(1, 2, 0, 32'h0020_A023, 0, 1, 0, 7, 0, 1, 1);
    repeat (150) rnd_instr(1);
    play(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
